// File: rtl/score_cmd_issuer.sv
// Turns judged step events into single-cycle UP1/UP2/DOWN1/DOWN2 pulses for the BCD score chain.
// Optional combo bonus (COMBO port, +1 after a perfect on a 10+ combo) is enabled by defining SCORE_COMBO_EN.
module score_cmd_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       JUDGE_VALID,
  input  logic [1:0] JUDGE_CODE,
  input  logic       SCORE_ZERO,
  input  logic       SCORE_ONE,
  output logic       UP1,
  output logic       UP2,
  output logic       DOWN1,
  output logic       DOWN2,
  output logic       BUSY,
  output logic       FULL,
  output logic       DROP
`ifdef SCORE_COMBO_EN
  ,
  output logic       COMBO
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q;
  logic [1:0]    code_q;
  logic [1:0]    head_code;
  logic          fifo_empty, fifo_full, pop, wr;
  logic          bonus_pend, bonus_now;
  logic          up1_d, up2_d, down1_d, down2_d;

  // Full check uses pre-pop occupancy, so a pop never frees room for a same-cycle write.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    pop        = (state_q == S_IDLE) && !fifo_empty;
    wr         = JUDGE_VALID && !fifo_full;
    count_d    = count_q + CW'(wr) - CW'(pop);
    head_code  = mem[rd_ptr];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (gap_q == GW'(1)) state_d = bonus_pend ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Floor guard: score flags are sampled during the ISSUE cycle itself.
  always_comb begin
    up1_d   = 1'b0;
    up2_d   = 1'b0;
    down1_d = 1'b0;
    down2_d = 1'b0;
    if (state_q == S_ISSUE) begin
      if (bonus_now) begin
        up1_d = 1'b1;
      end else begin
        unique case (code_q)
          2'b00: up2_d = 1'b1;
          2'b01: up1_d = 1'b1;
          2'b10: down1_d = !SCORE_ZERO;
          2'b11: begin
            down1_d = !SCORE_ZERO && SCORE_ONE;
            down2_d = !SCORE_ZERO && !SCORE_ONE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr) mem[wr_ptr] <= JUDGE_CODE;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      code_q  <= '0;
      UP1     <= 1'b0;
      UP2     <= 1'b0;
      DOWN1   <= 1'b0;
      DOWN2   <= 1'b0;
      BUSY    <= 1'b0;
      FULL    <= 1'b0;
      DROP    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        code_q <= head_code;
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      if (state_q == S_ISSUE)     gap_q <= GW'(GAP);
      else if (state_q == S_WAIT) gap_q <= gap_q - 1'b1;
      UP1   <= up1_d;
      UP2   <= up2_d;
      DOWN1 <= down1_d;
      DOWN2 <= down2_d;
      BUSY  <= (state_d != S_IDLE) || (count_d != '0);
      FULL  <= (count_d == CW'(DEPTH));
      DROP  <= JUDGE_VALID && fifo_full;
    end
  end

`ifdef SCORE_COMBO_EN
  logic [3:0] combo_q;
  logic       bonus_go;

  assign bonus_go = (state_q == S_WAIT) && (gap_q == GW'(1)) && bonus_pend;

  // Combo level is judged before the popped event updates it.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      combo_q    <= '0;
      bonus_pend <= 1'b0;
      bonus_now  <= 1'b0;
    end else if (pop) begin
      bonus_now  <= 1'b0;
      bonus_pend <= (head_code == 2'b00) && (combo_q >= 4'd10);
      if (head_code[1])          combo_q <= '0;
      else if (combo_q != 4'hF)  combo_q <= combo_q + 1'b1;
    end else if (bonus_go) begin
      bonus_now  <= 1'b1;
      bonus_pend <= 1'b0;
    end
  end

  assign COMBO = (combo_q >= 4'd10);
`else
  assign bonus_pend = 1'b0;
  assign bonus_now  = 1'b0;
`endif

endmodule

// File: tb/tb_score_cmd_issuer.sv
// Directed bench for score_cmd_issuer: event-timeline model compared every cycle plus literal checks.
module tb_score_cmd_issuer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;

  logic       clk = 1'b0;
  logic       rst, jv, sz, so;
  logic [1:0] jc;
  logic       up1, up2, dn1, dn2, busy, full, drop;
`ifdef SCORE_COMBO_EN
  logic       combo;
`endif

  score_cmd_issuer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .CLOCK(clk), .RESET(rst), .JUDGE_VALID(jv), .JUDGE_CODE(jc),
    .SCORE_ZERO(sz), .SCORE_ONE(so),
    .UP1(up1), .UP2(up2), .DOWN1(dn1), .DOWN2(dn2),
    .BUSY(busy), .FULL(full), .DROP(drop)
`ifdef SCORE_COMBO_EN
    , .COMBO(combo)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int now   = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, now);
    end
  endtask

  // Timeline model: pops happen on an edge when the issuer was idle the cycle before;
  // the command appears one cycle after the pop and the issuer is busy for GAP more cycles.
  int mq[$];
  int idle_at = 0, iss_cyc = -100, iss_code = 0, bonus_at = -100, mcombo = 0;
  bit iss_bonus = 0, model_on = 0;
  bit e_up1, e_up2, e_dn1, e_dn2, e_busy, e_full, e_drop, e_combo;

  always @(posedge clk) begin
    int pre, pc;
    bit took;
    now++;
    e_up1 = 0; e_up2 = 0; e_dn1 = 0; e_dn2 = 0; e_drop = 0;
    if (rst) begin
      mq.delete();
      idle_at  = now;
      iss_cyc  = -100;
      bonus_at = -100;
      mcombo   = 0;
      model_on = 1;
    end else if (model_on) begin
      if (iss_cyc == now - 1) begin
        if (iss_bonus) e_up1 = 1;
        else case (iss_code)
          0: e_up2 = 1;
          1: e_up1 = 1;
          2: e_dn1 = !sz;
          default: if (!sz) begin
            if (so) e_dn1 = 1;
            else    e_dn2 = 1;
          end
        endcase
      end
      if (bonus_at == now) begin
        iss_cyc   = now;
        iss_bonus = 1;
      end
      pre  = mq.size();
      took = 0;
      if (idle_at <= now - 1 && pre > 0) begin
        pc   = mq.pop_front();
        took = 1;
      end
      if (jv) begin
        if (pre == DEPTH) e_drop = 1;
        else              mq.push_back(int'(jc));
      end
      if (took) begin
        iss_cyc   = now;
        iss_code  = pc;
        iss_bonus = 0;
        idle_at   = now + GAP + 1;
`ifdef SCORE_COMBO_EN
        if (pc < 2) begin
          if (pc == 0 && mcombo >= 10) begin
            bonus_at = now + GAP + 1;
            idle_at  = now + 2 * GAP + 2;
          end
          if (mcombo < 15) mcombo++;
        end else begin
          mcombo = 0;
        end
`endif
      end
    end
    e_busy  = (mq.size() != 0) || (idle_at > now);
    e_full  = (mq.size() == DEPTH);
    e_combo = (mcombo >= 10);
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("UP1", int'(up1), int'(e_up1));
      chk("UP2", int'(up2), int'(e_up2));
      chk("DOWN1", int'(dn1), int'(e_dn1));
      chk("DOWN2", int'(dn2), int'(e_dn2));
      chk("BUSY", int'(busy), int'(e_busy));
      chk("FULL", int'(full), int'(e_full));
      chk("DROP", int'(drop), int'(e_drop));
`ifdef SCORE_COMBO_EN
      chk("COMBO", int'(combo), int'(e_combo));
`endif
    end
  end

  // Pulse log: kind 1=UP1 2=UP2 3=DOWN1 4=DOWN2
  int pcyc[$];
  int pkind[$];
  int drops = 0, last_busy = -1;
  bit full_seen = 0, busy_seen = 0;

  always @(negedge clk) begin
    if (up1) begin pcyc.push_back(now); pkind.push_back(1); end
    if (up2) begin pcyc.push_back(now); pkind.push_back(2); end
    if (dn1) begin pcyc.push_back(now); pkind.push_back(3); end
    if (dn2) begin pcyc.push_back(now); pkind.push_back(4); end
    if (drop) drops++;
    if (full) full_seen = 1;
    if (busy) begin busy_seen = 1; last_busy = now; end
  end

  function automatic int kind_at(input int i);
    return (i < pkind.size()) ? pkind[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < pcyc.size()) ? pcyc[i] : -1000;
  endfunction

  task automatic clear_mon();
    pcyc.delete();
    pkind.delete();
    drops = 0;
    full_seen = 0;
    busy_seen = 0;
    last_busy = -1;
  endtask

  task automatic push(input logic [1:0] c);
    jv = 1'b1;
    jc = c;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_idle_timeout"}, int'(i < 60), 1);
    repeat (2) @(negedge clk);
  endtask

  int c0;

  initial begin
    rst = 1'b1; jv = 1'b0; jc = 2'b00; sz = 1'b0; so = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_cmd", int'({up1, up2, dn1, dn2}), 0);
    @(negedge clk);

    // single perfect: sampled at edge c0+1, pulse after edge c0+3
    clear_mon();
    c0 = now;
    push(2'b00);
    jv = 1'b0;
    wait_idle("single");
    chk("single_count", pcyc.size(), 1);
    chk("single_kind", kind_at(0), 2);
    chk("single_latency", cyc_at(0), c0 + 3);
    chk("single_busy_low", int'(last_busy <= cyc_at(0) + GAP), 1);

    // burst of all four codes at mid score
    clear_mon();
    push(2'b00); push(2'b01); push(2'b10); push(2'b11);
    jv = 1'b0;
    wait_idle("burst");
    chk("burst_count", pcyc.size(), 4);
    chk("burst_k0", kind_at(0), 2);
    chk("burst_k1", kind_at(1), 1);
    chk("burst_k2", kind_at(2), 3);
    chk("burst_k3", kind_at(3), 4);
    for (int i = 0; i < 3; i++) chk("burst_spacing", cyc_at(i + 1) - cyc_at(i), GAP + 2);
    chk("burst_drops", drops, 0);

    // overflow: six back-to-back events, one dropped
    clear_mon();
    push(2'b00); push(2'b01); push(2'b00); push(2'b01); push(2'b00); push(2'b01);
    jv = 1'b0;
    wait_idle("ovf");
    chk("ovf_count", pcyc.size(), DEPTH + 1);
    chk("ovf_drops", drops, 1);
    chk("ovf_full_seen", int'(full_seen), 1);
    chk("ovf_k0", kind_at(0), 2);
    chk("ovf_k1", kind_at(1), 1);
    chk("ovf_k4", kind_at(4), 2);

    // floor guard at zero, then at one
    clear_mon();
    sz = 1'b1;
    push(2'b11);
    jv = 1'b0;
    wait_idle("floor_miss");
    push(2'b10);
    jv = 1'b0;
    wait_idle("floor_boo");
    chk("floor0_pulses", pcyc.size(), 0);
    chk("floor0_busy_seen", int'(busy_seen), 1);
    sz = 1'b0;
    so = 1'b1;
    clear_mon();
    push(2'b11);
    jv = 1'b0;
    wait_idle("floor_one");
    chk("floor1_count", pcyc.size(), 1);
    chk("floor1_kind", kind_at(0), 3);
    so = 1'b0;

    // reset while waiting with two events queued
    clear_mon();
    push(2'b00); push(2'b00); push(2'b00);
    jv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_full", int'(full), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_cmd", int'({up1, up2, dn1, dn2}), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rstmid_pulses", pcyc.size(), 1);

`ifdef SCORE_COMBO_EN
    for (int i = 0; i < 10; i++) begin
      push(2'b01);
      jv = 1'b0;
      wait_idle("combo_good");
      if (i == 8) chk("combo_after9", int'(combo), 0);
    end
    chk("combo_after10", int'(combo), 1);
    clear_mon();
    push(2'b00);
    jv = 1'b0;
    wait_idle("combo_perfect");
    chk("combo_count", pcyc.size(), 2);
    chk("combo_k0", kind_at(0), 2);
    chk("combo_k1", kind_at(1), 1);
    chk("combo_spacing", cyc_at(1) - cyc_at(0), GAP + 1);
    push(2'b11);
    jv = 1'b0;
    wait_idle("combo_miss");
    chk("combo_cleared", int'(combo), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_cmd_issuer.md
Name: score_cmd_issuer

Overview:
- Converts judged step events into the single-cycle UP1/UP2/DOWN1/DOWN2 command pulses consumed by the BCD score digit chain (counter0 on the ones digit).
- Sits between the step-judge logic and the score counter.
- Buffers bursts of events in a small FIFO and enforces inter-command spacing so that carry/borrow transients in the digit chain settle between commands.
- Guards the score floor so that a down-count is never issued past zero.

Parameters:
- DEPTH, 4, event FIFO entries (power of 2, 2..16).
- GAP, 2, idle cycles inserted after every issued command (>=1).

Ports:
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- JUDGE_VALID  in  1  one-cycle pulse, event present on JUDGE_CODE.
- JUDGE_CODE  in  2  event code: 00 perfect (+2), 01 good (+1), 10 boo (-1), 11 miss (-2).
- SCORE_ZERO  in  1  high when all four BCD score digits equal 0.
- SCORE_ONE  in  1  high when the score equals exactly 1.
- UP1  out  1  single-cycle +1 command.
- UP2  out  1  single-cycle +2 command.
- DOWN1  out  1  single-cycle -1 command.
- DOWN2  out  1  single-cycle -2 command.
- BUSY  out  1  FIFO non-empty or FSM not in IDLE.
- FULL  out  1  FIFO holds DEPTH entries.
- DROP  out  1  one-cycle pulse, the event on JUDGE_VALID was discarded because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high):
  - All command outputs, BUSY and DROP are 0.
  - FIFO is emptied, FULL = 0, FSM = IDLE.
  - RESET asserted mid-operation aborts any pending command and the gap count on the next edge; no command pulse is emitted in that cycle.
- Command output rules:
  - At most one of UP1/UP2/DOWN1/DOWN2 is high in any cycle.
  - Each command pulse is exactly 1 cycle wide and is registered.
- FIFO:
  - A write occurs on JUDGE_VALID when the FIFO is not full.
  - If JUDGE_VALID arrives when the FIFO is full, the event is dropped, DROP pulses on the next cycle, and FIFO contents are unchanged.
  - A simultaneous write and pop when full is NOT allowed: the full check uses the pre-pop occupancy.
  - FULL and BUSY are registered and reflect the post-edge occupancy.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if the FIFO is non-empty, pop the head and go to ISSUE.
  - ISSUE: drive exactly one command for one cycle, load the gap counter with GAP, go to WAIT.
  - WAIT: decrement the gap counter; at 0, return to IDLE.
- Timing:
  - Minimum latency from JUDGE_VALID (FIFO empty, IDLE) to the command pulse is 2 cycles.
  - Sustained throughput is one command per GAP+2 cycles.
- Floor guard: SCORE_ZERO and SCORE_ONE are sampled in the ISSUE cycle.
  - Code 10 with SCORE_ZERO: no pulse is emitted, but the state still transitions to WAIT.
  - Code 11 with SCORE_ZERO: no pulse.
  - Code 11 with SCORE_ONE: DOWN1 is emitted instead of DOWN2 (floor at 0).
  - Up commands are never suppressed. Score overflow at 9999 is the digit chain's concern.
- Simultaneous events: JUDGE_VALID during ISSUE or WAIT is enqueued normally; ordering is strict FIFO.

Optional Feature:
- Macro: SCORE_COMBO_EN.
- Defined:
  - A 4-bit saturating combo counter increments on each popped code 00 or 01, and clears on 10 or 11.
  - When the counter is >= 10 and a perfect is popped, ISSUE emits UP2, then after GAP idle cycles emits one extra UP1 (+3 total) before returning to IDLE.
  - Output COMBO (1 bit) is high while the counter is >= 10; it resets to 0.
- Undefined: no combo counter and no COMBO port; every perfect issues a single UP2.

Test Plan:
- Reset then single event: RESET high 2 cycles, then JUDGE_VALID with code 00 at cycle 5 -> UP2 high only at cycle 7; BUSY low by cycle 7+GAP+1.
- Burst: codes 00, 01, 10, 11 on 4 consecutive cycles, score 50 -> UP2, UP1, DOWN1, DOWN2 in that order, pulses spaced GAP+2=4 cycles apart, no DROP.
- Overflow: 6 back-to-back events with DEPTH=4 -> FULL asserts, DROP pulses for each discarded event, and only the first DEPTH+1 events issue (one is popped into ISSUE before the FIFO fills).
- Floor: SCORE_ZERO=1 with code 11 then 10 -> no command pulses, BUSY still cycles; SCORE_ONE=1 with code 11 -> DOWN1 pulse.
- Reset mid-WAIT: assert RESET during the gap with 2 queued events -> no further pulses, FULL=0, BUSY=0 after the edge.
- SCORE_COMBO_EN: 10 goods then 1 perfect -> COMBO high after the 10th good; the perfect produces UP2 followed GAP+1 cycles later by UP1; a subsequent miss clears COMBO.
